// File: rtl/game_status.sv
// game_status: move counter and win/loss judge downstream of the flood-fill
// engine. Watches the CHANGING_COLOR handshake, counts effective moves, scans
// the active SIZE x SIZE board one cell per cycle after each move, and
// publishes the flooded-cell count together with sticky win/loss flags.
//
// Build option: define GAME_STATUS_MOVE_LIMIT_EN to enable loss detection
// against MOVE_LIMIT. Without it GAME_LOST is tied low and MOVE_LIMIT is
// ignored.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a move, a new game or a pending rescan
// SCAN   | walking the active board row-major, one cell per cycle
// DECIDE | verdict cycle (STATUS_VALID high), then back to IDLE
module game_status #(
  parameter int BOARD_DIM = 26,
  parameter int COLOR_W   = 3,
  parameter int MOVE_W    = 7
) (
  input  logic                                   CLOCK,
  input  logic                                   RESET_N,
  input  logic [4:0]                             SIZE,
  input  logic [MOVE_W-1:0]                      MOVE_LIMIT,
  input  logic                                   STARTED_GAME,
  input  logic                                   CHANGING_COLOR,
  input  logic [BOARD_DIM*BOARD_DIM*COLOR_W-1:0] BOARD_FLAT,
  output logic [MOVE_W-1:0]                      MOVE_COUNT,
  output logic [9:0]                             FLOODED_COUNT,
  output logic                                   SCANNING,
  output logic                                   STATUS_VALID,
  output logic                                   GAME_WON,
  output logic                                   GAME_LOST
);

  localparam int IDX_W = $clog2(BOARD_DIM * BOARD_DIM);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;

  logic [1:0]         state;
  logic               chg_q;
  logic               pending_q;
  logic [COLOR_W-1:0] pre_color;
  logic [COLOR_W-1:0] ref_color;
  logic [4:0]         size_q;
  logic [4:0]         r;
  logic [4:0]         c;
  logic [9:0]         match_cnt;

  logic [4:0]         size_clamp;
  logic [COLOR_W-1:0] corner;
  logic [COLOR_W-1:0] cell_color;
  logic [IDX_W-1:0]   cell_idx;
  logic [9:0]         match_next;
  logic [9:0]         n_cells;
  logic               chg_rise;
  logic               chg_fall;
  logic               game_over;
  logic               eff_move;
  logic               last_col;
  logic               last_cell;
  logic               verdict;
  logic               win_now;
  logic               lost_q;

  // Sizes outside 2..BOARD_DIM are pulled into range so a scan always ends.
  always_comb begin
    size_clamp = SIZE;
    if (SIZE > 5'(BOARD_DIM)) begin
      size_clamp = 5'(BOARD_DIM);
    end else if (SIZE < 5'd2) begin
      size_clamp = 5'd2;
    end
  end

  assign corner     = BOARD_FLAT[COLOR_W-1:0];
  assign cell_idx   = IDX_W'(r) * IDX_W'(BOARD_DIM) + IDX_W'(c);
  assign cell_color = BOARD_FLAT[cell_idx*COLOR_W +: COLOR_W];
  assign match_next = match_cnt + {9'd0, (cell_color == ref_color)};
  assign n_cells    = 10'(size_q) * 10'(size_q);

  assign chg_rise  = CHANGING_COLOR & ~chg_q;
  assign chg_fall  = ~CHANGING_COLOR & chg_q;
  assign game_over = GAME_WON | lost_q;
  // A new-game pulse swallows any move that ends in the same cycle.
  assign eff_move  = chg_fall & (corner != pre_color) & ~game_over & ~STARTED_GAME;

  assign last_col  = (c == size_q - 5'd1);
  assign last_cell = (state == S_SCAN) & last_col & (r == size_q - 5'd1);
  assign verdict   = last_cell & ~STARTED_GAME;
  assign win_now   = (match_next == n_cells);

  // Edge detector on the engine handshake; corner colour captured at fill start.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      chg_q     <= 1'b0;
      pre_color <= '0;
    end else begin
      chg_q <= CHANGING_COLOR;
      if (chg_rise) begin
        pre_color <= corner;
      end
    end
  end

  // Effective-move counter, saturating, frozen once the game is decided.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      MOVE_COUNT <= '0;
    end else if (STARTED_GAME) begin
      MOVE_COUNT <= '0;
    end else if (eff_move && (MOVE_COUNT != '1)) begin
      MOVE_COUNT <= MOVE_COUNT + MOVE_W'(1);
    end
  end

  // Remembers a move that landed while a scan was busy so it gets rescanned.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q <= 1'b0;
    end else if (STARTED_GAME) begin
      pending_q <= 1'b0;
    end else if (eff_move && (state != S_IDLE)) begin
      pending_q <= 1'b1;
    end else if (state == S_IDLE) begin
      pending_q <= 1'b0;
    end
  end

  // Scan sequencer: latches the reference colour and walks the board.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= S_IDLE;
      ref_color     <= '0;
      size_q        <= 5'd2;
      r             <= '0;
      c             <= '0;
      match_cnt     <= '0;
      SCANNING      <= 1'b0;
      STATUS_VALID  <= 1'b0;
      FLOODED_COUNT <= '0;
    end else begin
      STATUS_VALID <= 1'b0;
      if (STARTED_GAME) begin
        state     <= S_SCAN;
        ref_color <= corner;
        size_q    <= size_clamp;
        r         <= '0;
        c         <= '0;
        match_cnt <= '0;
        SCANNING  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (eff_move || pending_q) begin
              state     <= S_SCAN;
              ref_color <= corner;
              size_q    <= size_clamp;
              r         <= '0;
              c         <= '0;
              match_cnt <= '0;
              SCANNING  <= 1'b1;
            end
          end
          S_SCAN: begin
            match_cnt <= match_next;
            if (last_cell) begin
              state         <= S_DECIDE;
              SCANNING      <= 1'b0;
              STATUS_VALID  <= 1'b1;
              FLOODED_COUNT <= match_next;
            end else if (last_col) begin
              c <= '0;
              r <= r + 5'd1;
            end else begin
              c <= c + 5'd1;
            end
          end
          S_DECIDE: begin
            state <= S_IDLE;
          end
          default: begin
            state    <= S_IDLE;
            SCANNING <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky win flag; a loss already recorded keeps the flags exclusive.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      GAME_WON <= 1'b0;
    end else if (STARTED_GAME) begin
      GAME_WON <= 1'b0;
    end else if (verdict && win_now && !lost_q) begin
      GAME_WON <= 1'b1;
    end
  end

`ifdef GAME_STATUS_MOVE_LIMIT_EN
  // Sticky loss flag. Deferred while a newer board is queued for rescan, so
  // the verdict on the final move decides (and a winning final move wins).
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      lost_q <= 1'b0;
    end else if (STARTED_GAME) begin
      lost_q <= 1'b0;
    end else if (verdict && !win_now && !GAME_WON && (MOVE_LIMIT != '0) &&
                 (MOVE_COUNT >= MOVE_LIMIT) && !pending_q && !eff_move) begin
      lost_q <= 1'b1;
    end
  end
`else
  logic unused_move_limit;
  assign unused_move_limit = ^MOVE_LIMIT;
  assign lost_q            = 1'b0;
`endif

  assign GAME_LOST = lost_q;

endmodule

// File: tb/tb_game_status.sv
// Bench for game_status: scoreboard of expected verdicts checked on every
// STATUS_VALID pulse, plus per-scenario timing checks.
module tb_game_status;
  localparam int BOARD_DIM = 26;
  localparam int COLOR_W   = 3;
  localparam int MOVE_W    = 7;
  localparam int BW        = BOARD_DIM * BOARD_DIM * COLOR_W;
`ifdef GAME_STATUS_MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic              CLOCK;
  logic              RESET_N;
  logic [4:0]        SIZE;
  logic [MOVE_W-1:0] MOVE_LIMIT;
  logic              STARTED_GAME;
  logic              CHANGING_COLOR;
  logic [BW-1:0]     board;
  logic [MOVE_W-1:0] MOVE_COUNT;
  logic [9:0]        FLOODED_COUNT;
  logic              SCANNING;
  logic              STATUS_VALID;
  logic              GAME_WON;
  logic              GAME_LOST;

  game_status #(.BOARD_DIM(BOARD_DIM), .COLOR_W(COLOR_W), .MOVE_W(MOVE_W)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .SIZE(SIZE), .MOVE_LIMIT(MOVE_LIMIT),
    .STARTED_GAME(STARTED_GAME), .CHANGING_COLOR(CHANGING_COLOR), .BOARD_FLAT(board),
    .MOVE_COUNT(MOVE_COUNT), .FLOODED_COUNT(FLOODED_COUNT), .SCANNING(SCANNING),
    .STATUS_VALID(STATUS_VALID), .GAME_WON(GAME_WON), .GAME_LOST(GAME_LOST)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [9:0]        fl;
    logic              won;
    logic              lost;
    logic [MOVE_W-1:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic logic [2:0] cell_get(int r, int c);
    return board[COLOR_W*(r*BOARD_DIM+c) +: COLOR_W];
  endfunction

  task automatic cell_set(int r, int c, logic [2:0] v);
    board[COLOR_W*(r*BOARD_DIM+c) +: COLOR_W] = v;
  endtask

  task automatic set_all(logic [2:0] v);
    for (int r = 0; r < BOARD_DIM; r++)
      for (int c = 0; c < BOARD_DIM; c++) cell_set(r, c, v);
  endtask

  // pattern 0: (r+c)%4, pattern 1: 5/6 checkerboard, pattern 2: (r+2c)%5+1
  task automatic set_pattern(int kind, logic [2:0] corner);
    for (int r = 0; r < BOARD_DIM; r++)
      for (int c = 0; c < BOARD_DIM; c++)
        case (kind)
          0:       cell_set(r, c, 3'((r + c) % 4));
          1:       cell_set(r, c, ((r + c) % 2 == 0) ? 3'd6 : 3'd5);
          default: cell_set(r, c, 3'(((r + 2*c) % 5) + 1));
        endcase
    cell_set(0, 0, corner);
  endtask

  function automatic logic [9:0] count_match(int sz);
    int n = 0;
    logic [2:0] k = cell_get(0, 0);
    for (int r = 0; r < sz; r++)
      for (int c = 0; c < sz; c++)
        if (cell_get(r, c) == k) n++;
    return 10'(n);
  endfunction

  task automatic push_exp(logic [9:0] fl, logic won, logic lost, int mc);
    exp_t e;
    e.fl = fl; e.won = won; e.lost = lost; e.mc = MOVE_W'(mc);
    exp_q.push_back(e);
  endtask

  task automatic start_game();
    @(negedge CLOCK) STARTED_GAME = 1'b1;
    @(negedge CLOCK) STARTED_GAME = 1'b0;
  endtask

  // Returns at the negedge right after the fall has been driven.
  task automatic do_move(logic [2:0] newc, bit uniform);
    @(negedge CLOCK) CHANGING_COLOR = 1'b1;
    @(negedge CLOCK);
    if (uniform) set_all(newc);
    else cell_set(0, 0, newc);
    @(negedge CLOCK) CHANGING_COLOR = 1'b0;
  endtask

  task automatic wait_verdict(int bound);
    int i = 0;
    do begin
      @(negedge CLOCK);
      i++;
    end while (!STATUS_VALID && i < bound);
    if (!STATUS_VALID) begin
      vectors++; errors++;
      $display("FAIL verdict_timeout no STATUS_VALID within %0d cycles", bound);
    end
  endtask

  // Scoreboard: every published verdict must match the oldest expectation.
  always @(negedge CLOCK) begin
    exp_t e;
    if (RESET_N && STATUS_VALID) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL verdict_unexpected flooded=%0d won=%0d lost=%0d", FLOODED_COUNT, GAME_WON, GAME_LOST);
      end else begin
        e = exp_q.pop_front();
        if (FLOODED_COUNT !== e.fl) begin
          errors++; $display("FAIL verdict_flooded got %0d want %0d", FLOODED_COUNT, e.fl);
        end
        if (GAME_WON !== e.won) begin
          errors++; $display("FAIL verdict_won got %0d want %0d", GAME_WON, e.won);
        end
        if (GAME_LOST !== e.lost) begin
          errors++; $display("FAIL verdict_lost got %0d want %0d", GAME_LOST, e.lost);
        end
        if (MOVE_COUNT !== e.mc) begin
          errors++; $display("FAIL verdict_move_count got %0d want %0d", MOVE_COUNT, e.mc);
        end
      end
    end
  end

  task automatic test_reset();
    RESET_N = 1'b0; SIZE = 5'd2; MOVE_LIMIT = '0;
    STARTED_GAME = 1'b0; CHANGING_COLOR = 1'b0; board = '0;
    repeat (3) @(negedge CLOCK);
    vectors++;
    if ({MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST} !== '0) begin
      errors++; $display("FAIL reset_held outputs=%h want 0", {MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST});
    end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK);
    vectors++;
    if ({MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST} !== '0) begin
      errors++; $display("FAIL reset_released outputs=%h want 0", {MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST});
    end
  endtask

  task automatic test_uniform_start();
    logic exp_scan;
    SIZE = 5'd2; MOVE_LIMIT = '0;
    set_all(3'd3);
    push_exp(10'd4, 1'b1, 1'b0, 0);
    @(negedge CLOCK) STARTED_GAME = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLOCK) STARTED_GAME = 1'b0;
      exp_scan = (i <= 4);
      vectors++;
      if (SCANNING !== exp_scan) begin
        errors++; $display("FAIL uniform_scanning cycle %0d got %0d want %0d", i, SCANNING, exp_scan);
      end
      if (i == 1) begin
        vectors++;
        if (MOVE_COUNT !== 7'd0) begin
          errors++; $display("FAIL uniform_move_count got %0d want 0", MOVE_COUNT);
        end
      end
      if (i == 5) begin
        vectors++;
        if (STATUS_VALID !== 1'b1 || GAME_WON !== 1'b1) begin
          errors++; $display("FAIL uniform_verdict valid=%0d won=%0d want 1 1", STATUS_VALID, GAME_WON);
        end
      end
    end
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic test_normal_move();
    SIZE = 5'd6; MOVE_LIMIT = '0;
    set_pattern(0, 3'd1);
    push_exp(count_match(6), 1'b0, 1'b0, 0);
    start_game();
    wait_verdict(60);
    do_move(3'd2, 1'b0);
    push_exp(count_match(6), 1'b0, 1'b0, 1);
    for (int i = 1; i <= 37; i++) begin
      @(negedge CLOCK);
      if (i == 1) begin
        vectors++;
        if (MOVE_COUNT !== 7'd1 || SCANNING !== 1'b1) begin
          errors++; $display("FAIL move_e1 count=%0d scanning=%0d want 1 1", MOVE_COUNT, SCANNING);
        end
      end
      if (i == 36) begin
        vectors++;
        if (SCANNING !== 1'b1 || STATUS_VALID !== 1'b0) begin
          errors++; $display("FAIL move_e36 scanning=%0d valid=%0d want 1 0", SCANNING, STATUS_VALID);
        end
      end
      if (i == 37) begin
        vectors++;
        if (STATUS_VALID !== 1'b1 || SCANNING !== 1'b0 || GAME_WON !== 1'b0 || GAME_LOST !== 1'b0) begin
          errors++; $display("FAIL move_e37 valid=%0d scanning=%0d won=%0d lost=%0d want 1 0 0 0", STATUS_VALID, SCANNING, GAME_WON, GAME_LOST);
        end
      end
    end
  endtask

  task automatic test_same_color();
    do_move(cell_get(0, 0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      vectors++;
      if (SCANNING !== 1'b0 || MOVE_COUNT !== 7'd1) begin
        errors++; $display("FAIL same_color scanning=%0d count=%0d want 0 1", SCANNING, MOVE_COUNT);
      end
    end
  endtask

  task automatic test_loss();
    bit saw_scan;
    SIZE = 5'd4; MOVE_LIMIT = 7'd3;
    set_pattern(1, 3'd0);
    push_exp(10'd1, 1'b0, 1'b0, 0);
    start_game();
    wait_verdict(30);
    for (int m = 1; m <= 3; m++) begin
      do_move(3'(m), 1'b0);
      push_exp(count_match(4), 1'b0, (m == 3) && LIMIT_EN, m);
      wait_verdict(30);
    end
    do_move(3'd4, 1'b0);
    if (LIMIT_EN) begin
      saw_scan = 1'b0;
      repeat (20) begin
        @(negedge CLOCK);
        if (SCANNING) saw_scan = 1'b1;
      end
      vectors++;
      if (saw_scan || MOVE_COUNT !== 7'd3 || GAME_LOST !== 1'b1) begin
        errors++; $display("FAIL loss_frozen scanned=%0d count=%0d lost=%0d want 0 3 1", saw_scan, MOVE_COUNT, GAME_LOST);
      end
    end else begin
      push_exp(10'd1, 1'b0, 1'b0, 4);
      wait_verdict(30);
      vectors++;
      if (MOVE_COUNT !== 7'd4) begin
        errors++; $display("FAIL loss_unlimited count=%0d want 4", MOVE_COUNT);
      end
    end
    set_pattern(1, 3'd0);
    push_exp(10'd1, 1'b0, 1'b0, 0);
    start_game();
    wait_verdict(30);
    for (int m = 1; m <= 2; m++) begin
      do_move(3'(m), 1'b0);
      push_exp(10'd1, 1'b0, 1'b0, m);
      wait_verdict(30);
    end
    do_move(3'd3, 1'b1);
    push_exp(10'd16, 1'b1, 1'b0, 3);
    wait_verdict(30);
    vectors++;
    if (GAME_WON !== 1'b1 || GAME_LOST !== 1'b0) begin
      errors++; $display("FAIL loss_winning_final won=%0d lost=%0d want 1 0", GAME_WON, GAME_LOST);
    end
    MOVE_LIMIT = '0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    SIZE = 5'd6;
    set_pattern(0, 3'd0);
    push_exp(count_match(6), 1'b0, 1'b0, 0);
    start_game();
    wait_verdict(60);
    do_move(3'd2, 1'b0);
    push_exp(count_match(6), 1'b0, 1'b0, 2);
    repeat (3) @(negedge CLOCK);
    do_move(3'd3, 1'b0);
    push_exp(count_match(6), 1'b0, 1'b0, 2);
    pulses = 0;
    repeat (120) begin
      @(negedge CLOCK);
      if (STATUS_VALID) pulses++;
    end
    vectors++;
    if (pulses != 2) begin
      errors++; $display("FAIL back_to_back_pulses got %0d want 2", pulses);
    end
  endtask

  task automatic test_overlap_start();
    int i;
    SIZE = 5'd26;
    set_pattern(2, 3'd1);
    push_exp(count_match(26), 1'b0, 1'b0, 0);
    start_game();
    wait_verdict(700);
    do_move(3'd7, 1'b0);
    repeat (100) @(negedge CLOCK);
    vectors++;
    if (SCANNING !== 1'b1 || MOVE_COUNT !== 7'd1) begin
      errors++; $display("FAIL overlap_midscan scanning=%0d count=%0d want 1 1", SCANNING, MOVE_COUNT);
    end
    @(negedge CLOCK) STARTED_GAME = 1'b1;
    push_exp(count_match(26), 1'b0, 1'b0, 0);
    @(negedge CLOCK) STARTED_GAME = 1'b0;
    vectors++;
    if (MOVE_COUNT !== 7'd0 || SCANNING !== 1'b1) begin
      errors++; $display("FAIL overlap_restart count=%0d scanning=%0d want 0 1", MOVE_COUNT, SCANNING);
    end
    i = 1;
    while (!STATUS_VALID && i < 700) begin
      @(negedge CLOCK);
      i++;
    end
    vectors++;
    if (i != 677) begin
      errors++; $display("FAIL overlap_latency verdict at cycle %0d want 677", i);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_move(3'd6, 1'b0);
    repeat (30) @(negedge CLOCK);
    vectors++;
    if (SCANNING !== 1'b1 || MOVE_COUNT !== 7'd1) begin
      errors++; $display("FAIL reset_pre scanning=%0d count=%0d want 1 1", SCANNING, MOVE_COUNT);
    end
    #2 RESET_N = 1'b0;
    #1;
    vectors++;
    if ({MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST} !== '0) begin
      errors++; $display("FAIL reset_async outputs=%h want 0", {MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST});
    end
    @(negedge CLOCK) RESET_N = 1'b1;
    repeat (5) begin
      @(negedge CLOCK);
      vectors++;
      if ({MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST} !== '0) begin
        errors++; $display("FAIL reset_idle outputs=%h want 0", {MOVE_COUNT, FLOODED_COUNT, SCANNING, STATUS_VALID, GAME_WON, GAME_LOST});
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform_start();
    test_normal_move();
    test_same_color();
    test_loss();
    test_back_to_back();
    test_overlap_start();
    test_reset_mid_scan();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain %0d verdicts missing want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
